// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS opcode/funct, state and datapath select encodings
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_NOP   = 6'b000000;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXE_R   = 4'd2,
        ST_EXE_I   = 4'd3,
        ST_MEM_ADR = 4'd4,
        ST_MEM_RD  = 4'd5,
        ST_MEM_WR  = 4'd6,
        ST_WB_ALU  = 4'd7,
        ST_WB_MEM  = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JUMP    = 4'd10,
        ST_HALT    = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADDU = 3'd0;
    localparam logic [2:0] ALU_SUBU = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_EQ   = 3'd3;

    localparam logic [2:0] EXT_ZERO = 3'd0;
    localparam logic [2:0] EXT_SIGN = 3'd1;
    localparam logic [2:0] EXT_LUI  = 3'd2;
    localparam logic [2:0] EXT_BR   = 3'd3;
    localparam logic [2:0] EXT_JMP  = 3'd4;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] WG_RT = 2'd0;
    localparam logic [1:0] WG_RD = 2'd1;
    localparam logic [1:0] WG_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_DM  = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;
    localparam logic [1:0] WD_EXT = 2'd3;

    // Exactly one bit is set for any opcode/funct pair.
    typedef struct packed {
        logic rtype_add;
        logic rtype_sub;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic nop;
        logic illegal;
    } inst_class_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - opcode/funct to one-hot instruction class
module mc_decode
    import mips_defs::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [11:0] cls
);

    inst_class_t c;

    // Classify the instruction; anything not recognised is illegal.
    always_comb begin
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: c.rtype_add = 1'b1;
                    FN_SUBU: c.rtype_sub = 1'b1;
                    FN_JR:   c.jr        = 1'b1;
                    FN_NOP:  c.nop       = 1'b1;
                    default: c.illegal   = 1'b1;
                endcase
            end
            OP_ORI:  c.ori     = 1'b1;
            OP_LUI:  c.lui     = 1'b1;
            OP_LW:   c.lw      = 1'b1;
            OP_SW:   c.sw      = 1'b1;
            OP_BEQ:  c.beq     = 1'b1;
            OP_J:    c.j       = 1'b1;
            OP_JAL:  c.jal     = 1'b1;
            default: c.illegal = 1'b1;
        endcase
    end

    assign cls = c;

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM with DM request/ack handshake
module mc_ctrl
    import mips_defs::*;
#(
    parameter int MEM_TIMEOUT = 16
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       cmp,
    input  logic       mem_ack,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       rf_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic [2:0] alu_op,
    output logic       alu_b_sel,
    output logic [2:0] ext_op,
    output logic [1:0] pc_sel,
    output logic [1:0] wg_sel,
    output logic [1:0] wd_sel,
    output logic [3:0] state,
    output logic       err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t          st;
    logic [11:0]     dec_bits;
    inst_class_t     cls_now;
    logic [CNT_W-1:0] wait_cnt;
    logic            err_q;

    // Instruction class latched in DECODE; only the bits later states need.
    logic q_rtype;
    logic q_sub;
    logic q_ori;
    logic q_lui;
    logic q_sw;
    logic q_jr;
    logic q_jal;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (dec_bits)
    );

    assign cls_now = inst_class_t'(dec_bits);

    // State sequencing, instruction latch, DM wait counter and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= ST_FETCH;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            q_rtype  <= 1'b0;
            q_sub    <= 1'b0;
            q_ori    <= 1'b0;
            q_lui    <= 1'b0;
            q_sw     <= 1'b0;
            q_jr     <= 1'b0;
            q_jal    <= 1'b0;
        end else begin
            case (st)
                ST_FETCH: st <= ST_DECODE;
                ST_DECODE: begin
                    q_rtype <= cls_now.rtype_add | cls_now.rtype_sub;
                    q_sub   <= cls_now.rtype_sub;
                    q_ori   <= cls_now.ori;
                    q_lui   <= cls_now.lui;
                    q_sw    <= cls_now.sw;
                    q_jr    <= cls_now.jr;
                    q_jal   <= cls_now.jal;
                    if (cls_now.rtype_add || cls_now.rtype_sub) begin
                        st <= ST_EXE_R;
                    end else if (cls_now.jr || cls_now.j || cls_now.jal) begin
                        st <= ST_JUMP;
                    end else if (cls_now.ori || cls_now.lui) begin
                        st <= ST_EXE_I;
                    end else if (cls_now.lw || cls_now.sw) begin
                        st <= ST_MEM_ADR;
                    end else if (cls_now.beq) begin
                        st <= ST_BRANCH;
                    end else if (cls_now.nop) begin
                        st <= ST_FETCH;
                    end else if (cls_now.illegal) begin
                        st    <= ST_HALT;
                        err_q <= 1'b1;
                    end else begin
                        st    <= ST_HALT;
                        err_q <= 1'b1;
                    end
                end
                ST_EXE_R, ST_EXE_I: st <= ST_WB_ALU;
                ST_MEM_ADR: st <= q_sw ? ST_MEM_WR : ST_MEM_RD;
                ST_MEM_RD, ST_MEM_WR: begin
                    // An ack on the final allowed cycle still completes the access.
                    if (mem_ack) begin
                        wait_cnt <= '0;
                        st       <= (st == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
                    end else if (wait_cnt == CNT_LAST) begin
                        wait_cnt <= '0;
                        st       <= ST_HALT;
                        err_q    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: st <= ST_FETCH;
                ST_HALT: st <= ST_HALT;
                default: begin
                    st    <= ST_HALT;
                    err_q <= 1'b1;
                end
            endcase
        end
    end

    // Moore output decode; forced idle while reset is held so mem_req drops at once.
    always_comb begin
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        rf_we     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        alu_op    = ALU_ADDU;
        alu_b_sel = 1'b0;
        ext_op    = EXT_ZERO;
        pc_sel    = PC_PLUS4;
        wg_sel    = WG_RT;
        wd_sel    = WD_ALU;
        if (reset) begin
            case (st)
                ST_FETCH: begin
                    ir_wr  = 1'b1;
                    pc_wr  = 1'b1;
                    pc_sel = PC_PLUS4;
                end
                ST_EXE_R, ST_EXE_I, ST_WB_ALU: begin
                    // Execute selects are held into writeback so lui can route EXT.
                    if (q_sub) begin
                        alu_op = ALU_SUBU;
                    end else if (q_ori) begin
                        alu_op    = ALU_OR;
                        alu_b_sel = 1'b1;
                        ext_op    = EXT_ZERO;
                    end else if (q_lui) begin
                        ext_op = EXT_LUI;
                    end
                    if (st == ST_WB_ALU) begin
                        rf_we = 1'b1;
                        if (q_rtype) begin
                            wg_sel = WG_RD;
                        end
                        if (q_lui) begin
                            wd_sel = WD_EXT;
                        end
                    end
                end
                ST_MEM_ADR, ST_MEM_RD, ST_MEM_WR: begin
                    alu_op    = ALU_ADDU;
                    alu_b_sel = 1'b1;
                    ext_op    = EXT_SIGN;
                    mem_req   = (st != ST_MEM_ADR);
                    mem_we    = (st == ST_MEM_WR);
                end
                ST_WB_MEM: begin
                    rf_we  = 1'b1;
                    wg_sel = WG_RT;
                    wd_sel = WD_DM;
                end
                ST_BRANCH: begin
                    alu_op = ALU_EQ;
                    ext_op = EXT_BR;
                    pc_sel = PC_BRANCH;
                    pc_wr  = cmp;
                end
                ST_JUMP: begin
                    pc_wr = 1'b1;
                    if (q_jr) begin
                        pc_sel = PC_RS;
                    end else begin
                        pc_sel = PC_JUMP;
                        ext_op = EXT_JMP;
                        if (q_jal) begin
                            rf_we  = 1'b1;
                            wg_sel = WG_RA;
                            wd_sel = WD_PC4;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = st;
    assign err   = err_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Replaces the single-cycle combinational decoder.
- Sequences fetch, decode, execute, memory and writeback over several cycles, driving PC, IR, GRF, ALU, EXT and DM enables and mux selects from the latched instruction.
- Owns the DM request/acknowledge handshake, so a slow data memory stalls the sequence.

Parameters:
- MEM_TIMEOUT, 16, cycles to wait for mem_ack before aborting the access and raising err.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- opcode  in  6  Instr[31:26] from the instruction register.
- funct  in  6  Instr[5:0] from the instruction register.
- cmp  in  1  ALU out[0]; 1 = operands equal (beq compare).
- mem_ack  in  1  DM access complete, 1-cycle pulse.
- pc_wr  out  1  PC load enable.
- ir_wr  out  1  instruction register load enable.
- rf_we  out  1  GRF write enable.
- mem_req  out  1  DM request, level.
- mem_we  out  1  DM write (valid with mem_req).
- alu_op  out  3  0 ADDU, 1 SUBU, 2 OR, 3 EQ (out[0]=1 when equal).
- alu_b_sel  out  1  0 rt data, 1 EXT output.
- ext_op  out  3  0 zero-ext, 1 sign-ext, 2 lui (imm<<16), 3 branch offset (sext<<2), 4 jump target.
- pc_sel  out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs data.
- wg_sel  out  2  0 rt, 1 rd, 2 $31.
- wd_sel  out  2  0 ALU, 1 DM data, 2 PC+4, 3 EXT.
- state  out  4  current state, for debug and bench.
- err  out  1  sticky; set on illegal instruction or memory timeout.

Behaviour:
- States:
  - FETCH=0, DECODE=1, EXE_R=2, EXE_I=3, MEM_ADR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10, HALT=11.
- Reset (reset==0, async):
  - state=FETCH, err=0, timeout counter=0.
  - All enables 0; all selects 0.
- All outputs are a Moore decode of the state register plus the latched opcode/funct. No output depends combinationally on mem_ack or cmp, except pc_wr in BRANCH.
- FETCH:
  - ir_wr=1, pc_wr=1, pc_sel=0.
  - Next state DECODE.
- DECODE:
  - No writes. Dispatch on opcode/funct:
    - R-type (000000) addu(100001)/subu(100011) -> EXE_R.
    - jr(001000) -> JUMP.
    - ori(001101), lui(001111) -> EXE_I.
    - lw(100011), sw(101011) -> MEM_ADR.
    - beq(000100) -> BRANCH.
    - j(000010), jal(000011) -> JUMP.
    - All-zero instruction (nop) -> FETCH.
    - Anything else -> HALT with err=1.
- EXE_R:
  - alu_b_sel=0; alu_op = ADDU or SUBU.
  - Next state WB_ALU.
- EXE_I:
  - ori: alu_b_sel=1, ext_op=0, alu_op=OR.
  - lui: ext_op=2.
  - Next state WB_ALU.
- WB_ALU:
  - rf_we=1.
  - R-type: wg_sel=1, wd_sel=0.
  - ori: wg_sel=0, wd_sel=0.
  - lui: wg_sel=0, wd_sel=3.
  - Next state FETCH.
- MEM_ADR:
  - alu_b_sel=1, ext_op=1, alu_op=ADDU.
  - Next state MEM_RD (lw) or MEM_WR (sw).
- MEM_RD / MEM_WR:
  - mem_req=1 held; mem_we=1 only in MEM_WR. ALU address selects stay as in MEM_ADR.
  - Stay until mem_ack; then MEM_RD -> WB_MEM, MEM_WR -> FETCH.
  - Counter increments each waiting cycle. When it reaches MEM_TIMEOUT without mem_ack: HALT, err=1.
  - Counter clears on leaving the state.
  - mem_ack outside MEM_RD/MEM_WR is ignored.
- WB_MEM:
  - rf_we=1, wg_sel=0, wd_sel=1.
  - Next state FETCH.
- BRANCH:
  - alu_b_sel=0, alu_op=EQ, ext_op=3, pc_sel=1, pc_wr=cmp.
  - PC already holds PC+4, so target = PC+4 + (sext(imm)<<2).
  - Next state FETCH.
- JUMP:
  - j: pc_sel=2, ext_op=4, pc_wr=1.
  - jal: same as j, plus rf_we=1, wg_sel=2, wd_sel=2. wd PC+4 here is the already-incremented PC, which the datapath supplies.
  - jr: pc_sel=3, pc_wr=1.
  - Next state FETCH.
- HALT:
  - All enables 0.
  - Remain until reset.
- Cycle counts:
  - R/ori/lui: 4.
  - lw: 5 + wait cycles.
  - sw: 4 + wait cycles.
  - beq/j/jal/jr: 3.
  - nop: 2.
- Reset mid-operation aborts immediately. mem_req drops asynchronously, with no write completion guaranteed.
- rf_we, pc_wr and mem_we never assert in the same cycle, except the jal JUMP cycle (rf_we + pc_wr).

Decomposition:
- Shared package mips_defs:
  - opcode/funct constants.
  - State encoding.
  - alu_op, ext_op, pc_sel, wg_sel, wd_sel encodings (also used by ALU, EXT and the muxes).
- One natural sub-module, mc_decode:
  - Combinational opcode/funct -> instruction-class one-hot (rtype_add, rtype_sub, jr, ori, lui, lw, sw, beq, j, jal, nop, illegal).
  - Consumed by the FSM for dispatch and output decode.

Test Plan:
- addu (opcode 0, funct 100001), no reset glitches -> states 0,1,2,7,0. rf_we=1 only in cycle 4 with wg_sel=1, wd_sel=0. pc_wr only in cycle 1.
- lw with mem_ack after 3 wait cycles -> states 0,1,4,5,5,5,8,0. mem_req high 3 cycles, mem_we=0. rf_we=1 in WB_MEM with wd_sel=1.
- beq with cmp=1, then cmp=0 -> pc_wr=1 with pc_sel=1 in BRANCH, then pc_wr=0. Both return to FETCH after 3 cycles.
- jal -> JUMP cycle shows pc_wr=1, pc_sel=2, ext_op=4, rf_we=1, wg_sel=2, wd_sel=2.
- sw with mem_ack never asserted, MEM_TIMEOUT=16 -> after 16 cycles in MEM_WR, state=HALT, err=1, mem_req=0. Stays HALT until reset=0.
- Opcode 111111 -> DECODE -> HALT, err=1. Assert reset=0 mid-cycle during a later MEM_RD -> state=0, mem_req=0 immediately, without waiting for a clock edge.
